// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared parameter checks and width helpers for the pipeline register chain
//
// Contents:
//   DEPTH_MIN / DEPTH_MAX  legal range of the chain depth
//   occ_width()            width of an occupancy count for a given depth
//   params_legal()         elaboration-time legality check of DEPTH/FLUSH_STAGES/HOLD_STAGE
//   DEPTH_DEFAULT / OCC_W  occupancy width of the default four-stage chain

package pipe_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flush and hold must each leave at least the last stage untouched so
    // that an older beat can still drain while the front of the chain is
    // squashed or frozen.
    function automatic bit params_legal(input int depth, input int flush_stages,
                                        input int hold_stage);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
               (flush_stages >= 1) && (flush_stages <= depth - 1) &&
               (hold_stage >= 1) && (hold_stage <= depth - 1);
    endfunction

    localparam int DEPTH_DEFAULT = 4;
    localparam int OCC_W = occ_width(DEPTH_DEFAULT);

endpackage

// File: rtl/pipe_chain_if.sv
// rtl/pipe_chain_if.sv - valid/ready/data handshake bundle for the pipeline chain
//
// Signals:
//   valid  producer offers data
//   ready  consumer accepts data this cycle
//   data   WIDTH-bit payload
// Modports:
//   master  drives valid/data, observes ready
//   slave   observes valid/data, drives ready

interface pipe_chain_if #(
    parameter int WIDTH = 32
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one slice of the pipeline chain (valid + payload registers)
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   squash       clear valid on the next edge (flush); payload kept
//   load         take prev_valid/prev_data on the next edge
//   prev_valid   incoming valid (already forced low for a bubble)
//   prev_data    incoming payload
//   valid, data  registered stage contents

module pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             squash,
    input  logic             load,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= prev_valid;
            // A bubble leaves the payload untouched to avoid needless toggles.
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - parametrised pipeline register chain with backpressure, hold and flush
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   up            input handshake (valid/data in, ready out) into stage 0
//   down          output handshake (valid/data out, ready in) from stage DEPTH-1
//   flush         squash stages 0..FLUSH_STAGES-1, bubble into FLUSH_STAGES
//   hold          freeze stages below HOLD_STAGE, bubble into HOLD_STAGE
//   stage_valid   valid bit of every stage
//   occupancy     number of valid stages

module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_STAGES = 2,
    parameter int HOLD_STAGE   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipe_chain_if.slave                   up,
    pipe_chain_if.master                  down,
    input  logic                          flush,
    input  logic                          hold,
    output logic [DEPTH-1:0]              stage_valid,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int CNT_W = occ_width(DEPTH);

    if (!params_legal(DEPTH, FLUSH_STAGES, HOLD_STAGE)) begin : g_param_check
        $error("pipe_chain: illegal DEPTH/FLUSH_STAGES/HOLD_STAGE combination");
    end

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             in_ready;
    logic             in_take;

    // A stage can move when it is empty or everything ahead of it moves, so
    // readiness ripples back from the output and empty stages absorb bubbles.
    always_comb begin
        rdy[DEPTH] = down.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] | rdy[i + 1];
        end
    end

    assign in_ready = rdy[0] & !hold & !flush;
    assign in_take  = up.valid & in_ready;
    assign up.ready = in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             squash;
        logic             freeze;
        logic             bubble;
        logic             load;
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_take;
            assign src_data  = up.data;
        end else begin : g_body
            assign src_valid = v[i - 1];
            assign src_data  = d[i - 1];
        end

        // Flush takes priority over hold; with flush high hold is ignored.
        assign squash = flush && (i < FLUSH_STAGES);
        assign freeze = !flush && hold && (i < HOLD_STAGE);
        assign bubble = flush ? (i == FLUSH_STAGES) : (hold && (i == HOLD_STAGE));
        assign load   = rdy[i] && !freeze;

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .squash     (squash),
            .load       (load),
            .prev_valid (src_valid && !bubble),
            .prev_data  (src_data),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    assign down.valid  = v[DEPTH - 1];
    assign down.data   = d[DEPTH - 1];
    assign stage_valid = v;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CNT_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// tb/tb_pipe_chain.sv - self-checking bench for pipe_chain against a behavioural model

module tb_pipe_chain;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int FS = 2;
    localparam int HS = 1;
    localparam int OW = pipe_pkg::OCC_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          hold;
    logic [D-1:0]  stage_valid;
    logic [OW-1:0] occupancy;

    int errors = 0;
    int checks = 0;

    pipe_chain_if #(.WIDTH(W)) up_if ();
    pipe_chain_if #(.WIDTH(W)) dn_if ();

    pipe_chain #(
        .WIDTH        (W),
        .DEPTH        (D),
        .FLUSH_STAGES (FS),
        .HOLD_STAGE   (HS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up          (up_if),
        .down        (dn_if),
        .flush       (flush),
        .hold        (hold),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: slot k holds the beat k edges into the chain.
    bit         mv [D];
    logic [W-1:0] md [D];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
    endfunction

    // A slot can advance when the consumer takes a beat or there is a hole
    // anywhere at or after it.
    function automatic bit m_can_move(input int i);
        if (dn_if.ready) return 1'b1;
        for (int j = i; j < D; j++) begin
            if (!mv[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_in_ready();
        return m_can_move(0) && !hold && !flush;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mv[i]);
        return n;
    endfunction

    function automatic logic [D-1:0] m_vec();
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) r[i] = mv[i];
        return r;
    endfunction

    task automatic model_step();
        bit           nv [D];
        logic [W-1:0] nd [D];
        bit           mov [D];
        bit           take;
        bit           sv;
        for (int i = 0; i < D; i++) begin
            nv[i]  = mv[i];
            nd[i]  = md[i];
            mov[i] = m_can_move(i);
        end
        take = up_if.valid && m_in_ready();
        for (int i = 0; i < D; i++) begin
            if (flush && i < FS) begin
                nv[i] = 1'b0;
            end else if (!flush && hold && i < HS) begin
                nv[i] = mv[i];
            end else if (mov[i]) begin
                if ((flush && i == FS) || (!flush && hold && i == HS)) sv = 1'b0;
                else if (i == 0) sv = take;
                else sv = mv[i-1];
                nv[i] = sv;
                if (sv) nd[i] = (i == 0) ? up_if.data : md[i-1];
            end
        end
        for (int i = 0; i < D; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
    endtask

    task automatic model_check();
        chk("in_ready", 64'(up_if.ready), 64'(m_in_ready()));
        chk("out_valid", 64'(dn_if.valid), 64'(mv[D-1]));
        if (mv[D-1]) chk("out_data", 64'(dn_if.data), 64'(md[D-1]));
        chk("stage_valid", 64'(stage_valid), 64'(m_vec()));
        chk("occupancy", 64'(occupancy), 64'(m_count()));
    endtask

    // Drive inputs just after the falling edge and compare combinational outputs.
    task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy,
                         input bit fl, input bit hd);
        up_if.valid = iv;
        up_if.data  = id;
        dn_if.ready = ordy;
        flush       = fl;
        hold        = hd;
        #1;
        model_check();
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    int           first;
    logic [W-1:0] got [$];
    logic [W:0]   trace [$];

    initial begin
        rst_n       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        flush       = 1'b0;
        hold        = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 64'(dn_if.valid), 64'd0);
        chk("rst_out_data", 64'(dn_if.data), 64'd0);
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(up_if.ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming 0x1..0x8 with out_ready high.
        first = -1;
        for (int k = 0; k < 14; k++) begin
            drive(k < 8, W'(k + 1), 1'b1, 1'b0, 1'b0);
            if (dn_if.valid) begin
                if (first < 0) first = k;
                got.push_back(dn_if.data);
            end
            tick();
        end
        chk("stream_latency", 64'(first), 64'd4);
        chk("stream_count", 64'(got.size()), 64'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_order", 64'(got[i]), 64'(i + 1));

        // Backpressure: fill with A0..A3 while out_ready is low.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, W'(32'hA0 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", 64'(up_if.ready), 64'd0);
        chk("bp_occupancy", 64'(occupancy), 64'd4);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_release_in_ready", 64'(up_if.ready), 64'd1);
        chk("bp_release_data", 64'(dn_if.data), 64'hA0);
        tick();
        for (int k = 1; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("bp_drain", 64'(dn_if.data), 64'(32'hA0 + k));
            tick();
        end

        // Bubble collapse: B0, two idle cycles, B1, all with out_ready low.
        drive(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("collapse_occupancy", 64'(occupancy), 64'd2);
        chk("collapse_stages", 64'(stage_valid), 64'hC);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("collapse_first", 64'(dn_if.data), 64'hB0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("collapse_second", 64'(dn_if.data), 64'hB1);
        tick();

        // Hold for one cycle while C1 sits in stage 0.
        drive(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0); trace.push_back({dn_if.valid, dn_if.data}); tick();
        drive(1'b1, 32'hC1, 1'b1, 1'b0, 1'b0); trace.push_back({dn_if.valid, dn_if.data}); tick();
        drive(1'b1, 32'hC2, 1'b1, 1'b0, 1'b1);
        chk("hold_in_ready", 64'(up_if.ready), 64'd0);
        trace.push_back({dn_if.valid, dn_if.data});
        tick();
        drive(1'b1, 32'hC2, 1'b1, 1'b0, 1'b0);
        chk("hold_bubble_stages", 64'(stage_valid), 64'h5);
        trace.push_back({dn_if.valid, dn_if.data});
        tick();
        drive(1'b1, 32'hC3, 1'b1, 1'b0, 1'b0); trace.push_back({dn_if.valid, dn_if.data}); tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            trace.push_back({dn_if.valid, dn_if.data});
            tick();
        end
        chk("hold_c0_cycle", 64'(trace[4]), {31'd0, 1'b1, 32'hC0});
        chk("hold_bubble_cycle", 64'(trace[5][W]), 64'd0);
        chk("hold_c1_cycle", 64'(trace[6]), {31'd0, 1'b1, 32'hC1});
        chk("hold_c2_cycle", 64'(trace[7]), {31'd0, 1'b1, 32'hC2});
        chk("hold_c3_cycle", 64'(trace[8]), {31'd0, 1'b1, 32'hC3});

        // Flush with D3 oldest in stage 3 down to D0 youngest in stage 0.
        for (int k = 3; k >= 0; k--) begin
            drive(1'b1, W'(32'hD0 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hEE, 1'b0, 1'b1, 1'b0);
        chk("flush_in_ready", 64'(up_if.ready), 64'd0);
        chk("flush_occ_before", 64'(occupancy), 64'd4);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_occ_after", 64'(occupancy), 64'd2);
        chk("flush_stages", 64'(stage_valid), 64'hC);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_exit_d3", 64'(dn_if.data), 64'hD3);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_exit_d2", 64'(dn_if.data), 64'hD2);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_bubble", 64'(dn_if.valid), 64'd0);
        tick();

        // Flush and hold together, then reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'(32'hE0 + k), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hE3, 1'b1, 1'b1, 1'b1);
        chk("flushhold_in_ready", 64'(up_if.ready), 64'd0);
        tick();
        drive(1'b1, 32'hE4, 1'b1, 1'b0, 1'b0);
        chk("flushhold_stages", 64'(stage_valid), 64'h8);
        tick();
        drive(1'b1, 32'hE5, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 32'hE6, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(dn_if.valid), 64'd0);
        chk("midrst_out_data", 64'(dn_if.data), 64'd0);
        chk("midrst_stage_valid", 64'(stage_valid), 64'd0);
        chk("midrst_occupancy", 64'(occupancy), 64'd0);
        chk("midrst_in_ready", 64'(up_if.ready), 64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
                  ($urandom % 16) == 0, ($urandom % 8) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
